// File: rtl/spi_shift_in_reg_if.sv
// Port bundle for the SPI serial-to-parallel receiver: serial pins, start/busy
// control and the valid/ack word handshake.
interface spi_shift_in_reg_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  shift_clk_in;
    logic                  in_bit;
    logic                  data_ack;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  data_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output start, shift_clk_in, in_bit, data_ack,
        input  out_data, data_valid, busy, overrun
    );

    modport slave (
        input  start, shift_clk_in, in_bit, data_ack,
        output out_data, data_valid, busy, overrun
    );
endinterface

// File: rtl/spi_shift_in_reg.sv
// SPI receive shifter: synchronises an external shift clock and data line, samples
// on falling edges MSB first, and hands each finished word over valid/ack.
module spi_shift_in_reg #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    spi_shift_in_reg_if.slave        bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] bit_sync_r;
    logic                   sclk_prev_r;
    logic                   sclk_s;
    logic                   bit_s;
    logic                   fall_s;

    state_t                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_nxt_s;
    // The top word bit is never needed: it only exists in the completed word.
    logic [DATA_WIDTH-2:0]  shift_reg_r, shift_reg_nxt_s;
    logic [DATA_WIDTH-1:0]  out_data_r, out_data_nxt_s;
    logic                   data_valid_r, data_valid_nxt_s;
    logic                   overrun_r, overrun_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic [DATA_WIDTH-1:0]  word_s;
    logic                   complete_s;

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign bit_s  = bit_sync_r[SYNC_STAGES-1];
    assign fall_s = sclk_prev_r & ~sclk_s;
    assign word_s = {shift_reg_r, bit_s};

    // Synchroniser chains preset high so an idle-high shift clock gives no fall after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b1}};
            bit_sync_r  <= {SYNC_STAGES{1'b1}};
            sclk_prev_r <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.shift_clk_in};
            bit_sync_r  <= {bit_sync_r[SYNC_STAGES-2:0], bus.in_bit};
            sclk_prev_r <= sclk_s;
        end
    end

    // Next-state, shifting and handshake decisions.
    always_comb begin
        state_nxt_s      = state_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        shift_reg_nxt_s  = shift_reg_r;
        out_data_nxt_s   = out_data_r;
        data_valid_nxt_s = data_valid_r;
        overrun_nxt_s    = overrun_r;
        complete_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s     = ST_SHIFT;
                    bit_cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_reg_nxt_s = {(DATA_WIDTH-1){1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start wins over a coincident fall, which is dropped.
                if (bus.start) begin
                    bit_cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_reg_nxt_s = {(DATA_WIDTH-1){1'b0}};
                end else if (fall_s) begin
                    shift_reg_nxt_s = word_s[DATA_WIDTH-2:0];
                    bit_cnt_nxt_s   = bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == LAST_BIT) begin
                        complete_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (bus.start) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        if (complete_s) begin
            if (!data_valid_r || bus.data_ack) begin
                out_data_nxt_s   = word_s;
                data_valid_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s    = 1'b1;
            end
        end else if (data_valid_r && bus.data_ack) begin
            data_valid_nxt_s = 1'b0;
        end else begin
            data_valid_nxt_s = data_valid_r;
        end

        busy_nxt_s = (state_nxt_s == ST_SHIFT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            shift_reg_r  <= {(DATA_WIDTH-1){1'b0}};
            out_data_r   <= {DATA_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_reg_r  <= shift_reg_nxt_s;
            out_data_r   <= out_data_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            overrun_r    <= overrun_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign bus.out_data   = out_data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_spi_shift_in_reg.sv
// Directed bench for spi_shift_in_reg: drives the serial pins bit by bit and
// checks the parallel handshake against hand-computed words.
module tb_spi_shift_in_reg;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    spi_shift_in_reg_if #(.DATA_WIDTH(32)) bus ();

    spi_shift_in_reg #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.data_ack = 1'b1;
        step(1);
        bus.data_ack = 1'b0;
    endtask

    // One full shift_clk_in period with the data held around the falling edge.
    task automatic send_bit(input logic b);
        bus.in_bit = b;
        step(2);
        bus.shift_clk_in = 1'b0;
        step(5);
        bus.shift_clk_in = 1'b1;
        step(5);
    endtask

    // MSB-first word; the last bit is cycle-accurate so timing and a coincident ack can be probed.
    task automatic send_word(input logic [31:0] w, input logic ack_last, input logic chk_timing,
                             input string tag);
        for (int i = 31; i >= 1; i--) send_bit(w[i]);
        bus.in_bit = w[0];
        step(2);
        bus.shift_clk_in = 1'b0;
        step(2);
        if (chk_timing) begin
            check_val({tag, "_valid_before"}, {31'd0, bus.data_valid}, 32'd0);
            check_val({tag, "_busy_before"},  {31'd0, bus.busy},       32'd1);
        end
        bus.data_ack = ack_last;
        step(1);
        bus.data_ack = 1'b0;
        if (chk_timing) begin
            check_val({tag, "_valid_after"}, {31'd0, bus.data_valid}, 32'd1);
            check_val({tag, "_busy_after"},  {31'd0, bus.busy},       32'd0);
            check_val({tag, "_data_after"},  bus.out_data,            w);
        end
        step(3);
        bus.shift_clk_in = 1'b1;
        step(5);
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.shift_clk_in = 1'b1;
        bus.in_bit       = 1'b0;
        bus.data_ack     = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        check_val("rst_data",    bus.out_data,              32'h0000_0000);
        check_val("rst_valid",   {31'd0, bus.data_valid},   32'd0);
        check_val("rst_busy",    {31'd0, bus.busy},         32'd0);
        check_val("rst_overrun", {31'd0, bus.overrun},      32'd0);

        // Basic word with exact completion timing.
        pulse_start();
        check_val("t1_busy_rise", {31'd0, bus.busy}, 32'd1);
        send_word(32'hA5C3_0F81, 1'b0, 1'b1, "t1");
        check_val("t1_overrun", {31'd0, bus.overrun}, 32'd0);

        // Overrun: unacked word followed by a second word.
        pulse_ack();
        check_val("t2_ack_clears", {31'd0, bus.data_valid}, 32'd0);
        pulse_start();
        send_word(32'h1234_5678, 1'b0, 1'b0, "t2a");
        check_val("t2_first_data", bus.out_data, 32'h1234_5678);
        check_val("t2_first_ovr",  {31'd0, bus.overrun}, 32'd0);
        pulse_start();
        send_word(32'hFFFF_0000, 1'b0, 1'b0, "t2b");
        check_val("t2_kept_data", bus.out_data,             32'h1234_5678);
        check_val("t2_overrun",   {31'd0, bus.overrun},     32'd1);
        check_val("t2_valid",     {31'd0, bus.data_valid},  32'd1);
        pulse_start();
        check_val("t2_start_clr_ovr",   {31'd0, bus.overrun},    32'd0);
        check_val("t2_start_keep_valid", {31'd0, bus.data_valid}, 32'd1);

        // Ack in the completion cycle lets the new word through (receiver already armed).
        send_word(32'hDEAD_BEEF, 1'b1, 1'b0, "t3");
        check_val("t3_valid",   {31'd0, bus.data_valid}, 32'd1);
        check_val("t3_data",    bus.out_data,            32'hDEAD_BEEF);
        check_val("t3_overrun", {31'd0, bus.overrun},    32'd0);

        // Abort after 17 bits and restart.
        pulse_ack();
        pulse_start();
        for (int i = 0; i < 17; i++) send_bit(1'b1);
        check_val("t4_no_valid_17", {31'd0, bus.data_valid}, 32'd0);
        check_val("t4_busy_17",     {31'd0, bus.busy},       32'd1);
        pulse_start();
        send_word(32'h0000_0001, 1'b0, 1'b0, "t4");
        check_val("t4_data",  bus.out_data,            32'h0000_0001);
        check_val("t4_valid", {31'd0, bus.data_valid}, 32'd1);

        // Edges while idle are ignored.
        pulse_ack();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check_val("t5_idle_valid", {31'd0, bus.data_valid}, 32'd0);
        check_val("t5_idle_busy",  {31'd0, bus.busy},       32'd0);
        pulse_start();
        send_word(32'h8000_0000, 1'b0, 1'b0, "t5");
        check_val("t5_data",  bus.out_data,            32'h8000_0000);
        check_val("t5_valid", {31'd0, bus.data_valid}, 32'd1);

        // Reset mid-word.
        pulse_ack();
        pulse_start();
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_val("t6_busy",  {31'd0, bus.busy},       32'd0);
        check_val("t6_valid", {31'd0, bus.data_valid}, 32'd0);
        check_val("t6_data",  bus.out_data,            32'h0000_0000);
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        check_val("t6_post_valid", {31'd0, bus.data_valid}, 32'd0);
        check_val("t6_post_busy",  {31'd0, bus.busy},       32'd0);
        check_val("t6_post_data",  bus.out_data,            32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/spi_shift_in_reg.md
# spi_shift_in_reg

Serial-to-parallel receiver, the receive-side counterpart of the SPI shift-out register. It samples a serial data line on falling edges of an externally generated shift clock, MSB first, and assembles DATA_WIDTH-bit words. Each completed word is presented on a parallel port with a valid/ack handshake. Everything runs in the single system clock domain: the shift clock and data are synchronised and edge-detected internally, not used as clocks.

## Interface
- DATA_WIDTH, 32, bits per received word.
- SYNC_STAGES, 2, synchroniser flops on shift_clk_in and in_bit (≥2).

- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms the receiver, clears bit counter and overrun.
- shift_clk_in  input  1  asynchronous serial shift clock; data is valid at its falling edge.
- in_bit  input  1  asynchronous serial data, MSB first.
- out_data  output  DATA_WIDTH  last accepted word; held until overwritten.
- data_valid  output  1  out_data holds an unacknowledged word.
- data_ack  input  1  consumer accepts out_data; sampled only while data_valid=1.
- busy  output  1  high while in SHIFT.
- overrun  output  1  sticky; a word completed while data_valid=1 and data_ack=0.

## Operation
- Both asynchronous inputs pass through identical SYNC_STAGES-deep chains; sclk_s and bit_s are the aligned chain outputs. sclk_prev is sclk_s registered once.
- fall = sclk_prev & ~sclk_s. This is a one-cycle pulse.
- States: IDLE, SHIFT.
  - IDLE: fall is ignored. start → SHIFT, with bit_cnt=0 and shift_reg=0.
  - SHIFT, on fall: shift_reg ← {shift_reg[W-2:0], bit_s}; bit_cnt ← bit_cnt+1.
  - SHIFT, on the fall where bit_cnt=W-1: the word {shift_reg[W-2:0], bit_s} completes. The FSM goes to IDLE (one start per word).
- Word completion:
  - If data_valid=0, or data_ack=1 in the same cycle: out_data ← word, data_valid ← 1.
  - If data_valid=1 and data_ack=0: the word is discarded, out_data is unchanged, and overrun ← 1.
- data_ack with data_valid=1 and no completion clears data_valid the next cycle. data_ack with data_valid=0 is ignored.
- start in SHIFT aborts the partial word and restarts at bit_cnt=0. start takes priority over a coincident fall, which is dropped.
- start clears overrun. It does not touch data_valid or out_data.
- bit_cnt width is clog2(DATA_WIDTH)+1. It never wraps, because completion forces IDLE.
- Reset values:
  - out_data=0, data_valid=0, busy=0, overrun=0.
  - State IDLE, bit_cnt=0, shift_reg=0.
  - Synchroniser chains and sclk_prev are 1, matching shift-clock idle-high. This prevents a spurious fall after reset.
- Reset mid-word drops the partial word. Reset overrides start and data_ack.

## Timing
- A falling edge at the pin produces fall SYNC_STAGES+1 clk edges later. The bit is captured on that same edge.
- data_valid and the new out_data are visible the clk cycle after the capture edge of bit W-1. busy drops in that same cycle.
- busy rises the cycle after start is sampled.
- shift_clk_in high and low phases must each be ≥ SYNC_STAGES+1 clk periods.
- in_bit must be stable at the pin from 1 clk period before to 1 clk period after each shift_clk_in falling edge.
- Back-to-back words need a start pulse between them. A start may be issued in the cycle busy drops.

## Test plan
- Reset, then start, then 32 falls carrying 0xA5C3_0F81 MSB first → data_valid=1 with out_data=0xA5C3_0F81 exactly one cycle after the 32nd fall pulse; busy=0; overrun=0.
- Receive 0x1234_5678 with data_ack held low, then start and receive 0xFFFF_0000 → out_data stays 0x1234_5678 and overrun=1. The next start clears overrun.
- Assert data_ack in the exact cycle the second word 0xDEAD_BEEF completes → data_valid stays 1, out_data=0xDEAD_BEEF, overrun=0.
- After 17 bits of a word, pulse start, then send 32 bits of 0x0000_0001 → out_data=0x0000_0001. No valid is produced after only the first 17 bits.
- Toggle shift_clk_in 10 times with no start, then start and send 0x8000_0000 → the earlier edges are ignored; out_data=0x8000_0000.
- Assert reset after 20 bits → busy=0, data_valid=0, out_data=0. The next 12 falls without a start produce nothing.
